bsg_nasti_to_fsb_master_connector: RTL and testbench

BSG_NASTI_TO_FSB_MASTER_CONNECTOR -- requirements
Module: bsg_nasti_to_fsb_master_connector

---
 rtl/bsg_nasti_to_fsb_master_connector.sv | 185 ++++++++++++++++++
 tb/tb_bsg_nasti_to_fsb_master_connector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nasti_to_fsb_master_connector.sv
// NASTI master side to FSB bridge: AR/AW/W requests packed into outbound FSB
// packets, inbound FSB packets unpacked into R/B responses.
module bsg_nasti_to_fsb_master_connector #(
  parameter int destid_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ar_v_i,
  output logic        ar_ready_o,
  input  logic [31:0] ar_addr_i,
  input  logic [4:0]  ar_id_i,
  input  logic [2:0]  ar_size_i,
  input  logic [7:0]  ar_len_i,
  input  logic        aw_v_i,
  output logic        aw_ready_o,
  input  logic [31:0] aw_addr_i,
  input  logic [4:0]  aw_id_i,
  input  logic [2:0]  aw_size_i,
  input  logic [7:0]  aw_len_i,
  input  logic        w_v_i,
  output logic        w_ready_o,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_strb_i,
  input  logic        w_last_i,
  output logic        r_v_o,
  input  logic        r_ready_i,
  output logic [63:0] r_data_o,
  output logic [4:0]  r_id_o,
  output logic [1:0]  r_resp_o,
  output logic        r_last_o,
  output logic        b_v_o,
  input  logic        b_ready_i,
  output logic [4:0]  b_id_o,
  output logic [1:0]  b_resp_o,
  output logic        fsb_v_o,
  output logic [79:0] fsb_data_o,
  input  logic        fsb_yumi_i,
  input  logic        fsb_v_i,
  input  logic [79:0] fsb_data_i,
  output logic        fsb_ready_o,
  output logic [7:0]  drop_count_o
);

  typedef enum logic {IDLE, WDATA} state_e;

  localparam logic [3:0] DestId = 4'(destid_p);
  localparam logic [1:0] TypeA  = 2'b00;
  localparam logic [1:0] TypeAw = 2'b01;
  localparam logic [1:0] TypeW  = 2'b10;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        prio_aw_q;
  logic        out_v_q;
  logic [79:0] out_data_q, pkt_d;
  logic        in_v_q;
  logic [79:0] in_data_q;
  logic [7:0]  drop_q;

  logic slot_free, ar_hs, aw_hs, w_hs;
  logic in_acc, in_bad, in_clr;
  logic unused_bits;

  assign slot_free = ~out_v_q | fsb_yumi_i;
  assign ar_hs     = ar_v_i & ar_ready_o;
  assign aw_hs     = aw_v_i & aw_ready_o;
  assign w_hs      = w_v_i & w_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          cnt_d   = aw_len_i;
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin: prio_aw_q set means AR won the last grant
  always_comb begin
    ar_ready_o = 1'b0;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        IDLE: begin
          ar_ready_o = slot_free & ar_v_i & (~aw_v_i | ~prio_aw_q);
          aw_ready_o = slot_free & aw_v_i & (~ar_v_i | prio_aw_q);
        end
        WDATA: w_ready_o = slot_free;
        default: ;
      endcase
    end
  end

  always_comb begin
    pkt_d = out_data_q;
    unique case (1'b1)
      ar_hs: pkt_d = {DestId, 1'b0, TypeA, 25'b0,
                      ar_len_i, ar_size_i, ar_id_i, ar_addr_i};
      aw_hs: pkt_d = {DestId, 1'b0, TypeAw, 25'b0,
                      aw_len_i, aw_size_i, aw_id_i, aw_addr_i};
      w_hs:  pkt_d = {DestId, 1'b0, TypeW,
                      w_last_i, w_strb_i, w_data_i};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_aw_q  <= 1'b0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (ar_hs) prio_aw_q <= 1'b1;
      else if (aw_hs) prio_aw_q <= 1'b0;
      if (ar_hs | aw_hs | w_hs) begin
        out_v_q    <= 1'b1;
        out_data_q <= pkt_d;
      end else if (fsb_yumi_i) begin
        out_v_q <= 1'b0;
      end
    end
  end

  assign fsb_v_o    = out_v_q & ~reset_i;
  assign fsb_data_o = out_data_q;

  // Only cmd=0 packets of type R or B are worth buffering
  assign in_acc = fsb_v_i & fsb_ready_o;
  assign in_bad = fsb_data_i[75] | fsb_data_i[74];
  assign in_clr = (r_v_o & r_ready_i) | (b_v_o & b_ready_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_v_q    <= 1'b0;
      in_data_q <= '0;
      drop_q    <= '0;
    end else begin
      if (in_acc & ~in_bad) begin
        in_v_q    <= 1'b1;
        in_data_q <= fsb_data_i;
      end else if (in_clr) begin
        in_v_q <= 1'b0;
      end
      if (in_acc & in_bad & (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
    end
  end

  assign fsb_ready_o  = ~in_v_q & ~reset_i;
  assign drop_count_o = drop_q;

  assign r_v_o    = in_v_q & ~reset_i & (in_data_q[73] == 1'b0);
  assign b_v_o    = in_v_q & ~reset_i & (in_data_q[73] == 1'b1);
  assign r_data_o = in_data_q[63:0];
  assign r_id_o   = in_data_q[68:64];
  assign r_resp_o = in_data_q[70:69];
  assign r_last_o = in_data_q[71];
  assign b_id_o   = in_data_q[4:0];
  assign b_resp_o = in_data_q[6:5];

  assign unused_bits = ^{in_data_q[79:74], in_data_q[72]};

endmodule

// File: tb/tb_bsg_nasti_to_fsb_master_connector.sv
// Directed bench for the NASTI-to-FSB master connector.
module tb_bsg_nasti_to_fsb_master_connector;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ar_v_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [4:0]  ar_id_i;
  logic [2:0]  ar_size_i;
  logic [7:0]  ar_len_i;
  logic        aw_v_i, aw_ready_o;
  logic [31:0] aw_addr_i;
  logic [4:0]  aw_id_i;
  logic [2:0]  aw_size_i;
  logic [7:0]  aw_len_i;
  logic        w_v_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic        r_v_o, r_ready_i;
  logic [63:0] r_data_o;
  logic [4:0]  r_id_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        b_v_o, b_ready_i;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        fsb_v_o;
  logic [79:0] fsb_data_o;
  logic        fsb_yumi_i;
  logic        fsb_v_i;
  logic [79:0] fsb_data_i;
  logic        fsb_ready_o;
  logic [7:0]  drop_count_o;

  int n_chk = 0;
  int n_pass = 0;

  bsg_nasti_to_fsb_master_connector #(.destid_p(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ar_v_i(ar_v_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_size_i(ar_size_i), .ar_len_i(ar_len_i),
    .aw_v_i(aw_v_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_id_i(aw_id_i), .aw_size_i(aw_size_i), .aw_len_i(aw_len_i),
    .w_v_i(w_v_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .r_v_o(r_v_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_id_o(r_id_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .b_v_o(b_v_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o),
    .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i),
    .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_ready_o(fsb_ready_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [79:0] pa(input logic [1:0] t,
    input logic [31:0] a, input logic [4:0] id,
    input logic [2:0] sz, input logic [7:0] len);
    return {4'h1, 1'b0, t, 25'b0, len, sz, id, a};
  endfunction

  function automatic logic [79:0] pw(input logic [63:0] d,
    input logic [7:0] s, input logic l);
    return {4'h1, 1'b0, 2'b10, l, s, d};
  endfunction

  logic [2:0]  rdy3 [6];
  logic [79:0] pkt_r, pkt_b;

  initial begin
    reset_i = 1'b1;
    ar_v_i = 0; ar_addr_i = 0; ar_id_i = 0; ar_size_i = 0; ar_len_i = 0;
    aw_v_i = 0; aw_addr_i = 0; aw_id_i = 0; aw_size_i = 0; aw_len_i = 0;
    w_v_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    r_ready_i = 0; b_ready_i = 0; fsb_yumi_i = 1;
    fsb_v_i = 0; fsb_data_i = 0;

    // reset: everything quiet even with requests pending
    ar_v_i = 1; fsb_v_i = 1;
    step();
    chk("rst_ar_ready", 80'(ar_ready_o), 80'd0);
    chk("rst_fsb_v", 80'(fsb_v_o), 80'd0);
    chk("rst_fsb_ready", 80'(fsb_ready_o), 80'd0);
    chk("rst_rb_v", 80'({r_v_o, b_v_o}), 80'd0);
    chk("rst_drop", 80'(drop_count_o), 80'd0);
    reset_i = 0; ar_v_i = 0; fsb_v_i = 0;
    step();

    // single AR
    ar_v_i = 1; ar_addr_i = 32'h8000_0040; ar_id_i = 5'd3;
    ar_size_i = 3'd3; ar_len_i = 8'd0;
    #1 chk("ar_ready", 80'({ar_ready_o, aw_ready_o}), 80'b10);
    step();
    ar_v_i = 0;
    #1 chk("ar_pkt_v", 80'(fsb_v_o), 80'd1);
    chk("ar_pkt", fsb_data_o,
        {4'h1, 1'b0, 2'b00, 25'b0, 8'd0, 3'd3, 5'd3, 32'h8000_0040});
    chk("ar_ready_drop", 80'(ar_ready_o), 80'd0);
    step();
    chk("ar_consumed", 80'(fsb_v_o), 80'd0);

    // AW burst of 4 beats while AR is held
    aw_v_i = 1; aw_addr_i = 32'h1000; aw_id_i = 5'd1;
    aw_size_i = 3'd3; aw_len_i = 8'd3;
    ar_v_i = 1; ar_addr_i = 32'h2000; ar_id_i = 5'd2; ar_size_i = 3'd2;
    #1 chk("aw_win", 80'({ar_ready_o, aw_ready_o}), 80'b01);
    step();
    aw_v_i = 0;
    for (int i = 0; i < 4; i++) begin
      w_v_i = 1; w_data_i = 64'h1111_0000 + 64'(i);
      w_strb_i = 8'hF0 | 8'(i); w_last_i = (i == 3);
      #1;
      chk("wd_rdy", 80'({ar_ready_o, aw_ready_o, w_ready_o}), 80'b001);
      if (i == 0)
        chk("aw_pkt", fsb_data_o, pa(2'b01, 32'h1000, 5'd1, 3'd3, 8'd3));
      else
        chk("w_pkt", fsb_data_o,
            pw(64'h1111_0000 + 64'(i - 1), 8'hF0 | 8'(i - 1), 1'b0));
      step();
    end
    w_v_i = 0;
    #1 chk("w_last_pkt", fsb_data_o, pw(64'h1111_0003, 8'hF3, 1'b1));
    chk("ar_after_w", 80'({ar_ready_o, w_ready_o}), 80'b10);
    step();
    ar_v_i = 0;
    #1 chk("ar2_pkt", fsb_data_o, pa(2'b00, 32'h2000, 5'd2, 3'd2, 8'd0));

    // round robin with len 0 bursts: AW, W, AR, AW, W, AR
    rdy3[0] = 3'b010; rdy3[1] = 3'b001; rdy3[2] = 3'b100;
    rdy3[3] = 3'b010; rdy3[4] = 3'b001; rdy3[5] = 3'b100;
    ar_v_i = 1; aw_v_i = 1; aw_len_i = 8'd0; w_v_i = 1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr", 80'({ar_ready_o, aw_ready_o, w_ready_o}), 80'(rdy3[k]));
      step();
    end
    ar_v_i = 0; aw_v_i = 0; w_v_i = 0;
    step();

    // backpressure on the outbound slot
    fsb_yumi_i = 0;
    ar_v_i = 1; ar_addr_i = 32'hA; ar_id_i = 5'd4; ar_size_i = 3'd1;
    #1 chk("bp_grant", 80'(ar_ready_o), 80'd1);
    step();
    ar_addr_i = 32'hB;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_v", 80'(fsb_v_o), 80'd1);
      chk("bp_data", fsb_data_o, pa(2'b00, 32'hA, 5'd4, 3'd1, 8'd0));
      chk("bp_rdy", 80'({ar_ready_o, aw_ready_o, w_ready_o}), 80'd0);
      step();
    end
    fsb_yumi_i = 1;
    #1 chk("bp_resume", 80'(ar_ready_o), 80'd1);
    step();
    ar_addr_i = 32'hC;
    #1 chk("b2b_1", fsb_data_o, pa(2'b00, 32'hB, 5'd4, 3'd1, 8'd0));
    step();
    ar_v_i = 0;
    #1 chk("b2b_2", fsb_data_o, pa(2'b00, 32'hC, 5'd4, 3'd1, 8'd0));
    chk("b2b_v", 80'(fsb_v_o), 80'd1);
    step();
    chk("b2b_empty", 80'(fsb_v_o), 80'd0);

    // inbound R held, then B only after R handshake
    pkt_r = {4'h0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 5'd7,
             64'hDEAD_BEEF_0000_0001};
    pkt_b = {4'h0, 1'b0, 2'b01, 66'b0, 2'b10, 5'd9};
    fsb_v_i = 1; fsb_data_i = pkt_r;
    #1 chk("in_ready", 80'(fsb_ready_o), 80'd1);
    step();
    fsb_data_i = pkt_b;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("r_hold", 80'({r_v_o, b_v_o, fsb_ready_o}), 80'b100);
      chk("r_fields", {r_data_o, r_id_o, r_resp_o, r_last_o},
          80'({64'hDEAD_BEEF_0000_0001, 5'd7, 2'b00, 1'b1}));
      step();
    end
    r_ready_i = 1;
    #1 chk("r_hs", 80'(r_v_o), 80'd1);
    step();
    r_ready_i = 0;
    #1 chk("b_accept", 80'({r_v_o, fsb_ready_o}), 80'b01);
    step();
    fsb_v_i = 0;
    #1 chk("b_v", 80'({r_v_o, b_v_o}), 80'b01);
    chk("b_fields", 80'({b_id_o, b_resp_o}), 80'({5'd9, 2'b10}));
    b_ready_i = 1;
    step();
    b_ready_i = 0;
    #1 chk("b_clr", 80'(b_v_o), 80'd0);

    // dropped packets and counter saturation
    fsb_v_i = 1; fsb_data_i = {4'h0, 1'b0, 2'b10, 73'd5};
    repeat (3) step();
    chk("drop_t10", 80'(drop_count_o), 80'd3);
    fsb_data_i = {4'h0, 1'b1, 2'b00, 73'd5};
    repeat (249) step();
    chk("drop_252", 80'(drop_count_o), 80'd252);
    chk("drop_norb", 80'({r_v_o, b_v_o}), 80'd0);
    repeat (48) step();
    chk("drop_sat", 80'(drop_count_o), 80'd255);
    fsb_v_i = 0; reset_i = 1;
    step();
    reset_i = 0;
    #1 chk("drop_rst", 80'(drop_count_o), 80'd0);

    // reset in the middle of a burst
    aw_v_i = 1; aw_len_i = 8'd3;
    #1 chk("mb_aw", 80'(aw_ready_o), 80'd1);
    step();
    aw_v_i = 0; w_v_i = 1;
    #1 chk("mb_w", 80'(w_ready_o), 80'd1);
    step();
    reset_i = 1;
    #1 chk("mb_rst_v", 80'({fsb_v_o, w_ready_o}), 80'd0);
    step();
    reset_i = 0; ar_v_i = 1;
    #1 chk("mb_idle", 80'({ar_ready_o, aw_ready_o, w_ready_o}), 80'b100);
    chk("mb_empty", 80'(fsb_v_o), 80'd0);
    step();
    ar_v_i = 0; w_v_i = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
